// File: rtl/msk_holder_loader.sv
// Loader/refresh sequencer for a masked shift-register share holder.
// Streams shared words in, then rotates the full holder with fresh randomness on request.
module msk_holder_loader #(
    parameter int d          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [d*RFRSH_RATE-1:0]       in_data,
    input  logic                          rnd_valid,
    output logic                          rnd_ready,
    input  logic [(d-1)*RFRSH_RATE-1:0]   rnd_in,
    input  logic                          refresh_req,
    input  logic                          flush,
    output logic [d*RFRSH_RATE-1:0]       shares_data_out,
    output logic [(d-1)*RFRSH_RATE-1:0]   rnd_rfrsh_out,
    output logic                          fetch_out,
    output logic [d-1:0]                  enable_out,
    output logic                          data_valid,
    output logic                          busy
);

    localparam int NSTAGES = BITS / RFRSH_RATE;
    localparam int CW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTAGES - 1);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam logic [1:0] REFRESH = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          rotate;
    logic          last;

    assign shares_data_out = in_data;
    assign rnd_rfrsh_out   = rnd_in;

    // Handshakes are suppressed while reset or flush is asserted so the
    // holder never shifts on a cycle whose state update is being discarded.
    assign in_ready  = ~rst & ~flush & ((state == EMPTY) | (state == LOAD));
    assign rnd_ready = ~rst & ~flush & (state == REFRESH);

    assign accept = in_valid & in_ready;
    assign rotate = rnd_valid & rnd_ready;
    assign last   = (cnt == LAST);

    assign enable_out = {d{accept | rotate}};
    assign fetch_out  = (state != REFRESH);
    assign data_valid = (state == FULL);
    assign busy       = (state == LOAD) | (state == REFRESH);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        if (NSTAGES == 1) begin
                            state_nxt = FULL;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = LOAD;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last) begin
                            state_nxt = FULL;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (refresh_req) begin
                        state_nxt = REFRESH;
                        cnt_nxt   = '0;
                    end
                end
                REFRESH: begin
                    // A full pass of NSTAGES rotations restores word order.
                    if (rotate) begin
                        if (last) begin
                            state_nxt = FULL;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_msk_holder_loader.sv
// Bench for msk_holder_loader: directed scenarios plus random traffic,
// checked against a word-queue model and a behavioural holder.
module tb_msk_holder_loader;

    localparam int D    = 2;
    localparam int BITS = 256;
    localparam int RR   = 16;
    localparam int NS   = BITS / RR;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [D*RR-1:0] in_data;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [RR-1:0]   rnd_in;
    logic            refresh_req;
    logic            flush;
    logic [D*RR-1:0] shares_data_out;
    logic [RR-1:0]   rnd_rfrsh_out;
    logic            fetch_out;
    logic [D-1:0]    enable_out;
    logic            data_valid;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [RR-1:0] words[$];
    int            rot_left;
    logic [RR-1:0] h0[NS];
    logic [RR-1:0] h1[NS];
    logic [RR-1:0] cur_word;

    msk_holder_loader #(.d(D), .BITS(BITS), .RFRSH_RATE(RR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
        .refresh_req(refresh_req), .flush(flush),
        .shares_data_out(shares_data_out), .rnd_rfrsh_out(rnd_rfrsh_out),
        .fetch_out(fetch_out), .enable_out(enable_out),
        .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_in(bit iv, bit rv, bit rr, bit fl);
        logic [RR-1:0] m;
        m           = RR'($urandom);
        cur_word    = RR'($urandom);
        in_valid    = iv;
        rnd_valid   = rv;
        refresh_req = rr;
        flush       = fl;
        in_data     = {m, cur_word ^ m};
        rnd_in      = RR'($urandom);
    endtask

    // Advance one clock; holder follows DUT outputs, model follows the rules.
    task automatic tick();
        bit            acc, rv, full;
        logic [D-1:0]  en;
        logic          fe;
        logic [D*RR-1:0] sd;
        logic [RR-1:0] rn, t0, t1;
        #1;
        en   = enable_out;
        fe   = fetch_out;
        sd   = shares_data_out;
        rn   = rnd_rfrsh_out;
        full = (words.size() == NS) && (rot_left == 0);
        acc  = in_valid && !rst && !flush && (words.size() < NS);
        rv   = rnd_valid && !rst && !flush && (rot_left > 0);
        @(posedge clk);
        if (en == 2'b11) begin
            t0 = fe ? sd[RR-1:0]    : (h0[0] ^ rn);
            t1 = fe ? sd[2*RR-1:RR] : (h1[0] ^ rn);
            for (int i = 0; i < NS - 1; i++) begin
                h0[i] = h0[i+1];
                h1[i] = h1[i+1];
            end
            h0[NS-1] = t0;
            h1[NS-1] = t1;
        end
        if (rst || flush) begin
            words.delete();
            rot_left = 0;
        end else begin
            if (acc) words.push_back(cur_word);
            if (full && refresh_req) rot_left = NS;
            if (rv) rot_left--;
        end
        #1;
    endtask

    function automatic bit holder_ok();
        if (words.size() != NS) return 1'b0;
        for (int i = 0; i < NS; i++)
            if ((h0[i] ^ h1[i]) !== words[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 1, 1, 0);
        tick();
        tick();
        #1;
        total++;
        if (rnd_ready !== 1'b0) begin
            bad++; $display("FAIL rst_rnd_ready got=%b exp=0", rnd_ready);
        end
        total++;
        if (enable_out !== 2'b00) begin
            bad++; $display("FAIL rst_enable got=%b exp=00", enable_out);
        end
        total++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_status got=%b%b exp=00", data_valid, busy);
        end
        rst = 1'b0;
        set_in(0, 1, 1, 0);
        #1;
        total++;
        if (in_ready !== 1'b1 || rnd_ready !== 1'b0) begin
            bad++; $display("FAIL post_rst_ready got=%b%b exp=10", in_ready, rnd_ready);
        end
        total++;
        if (enable_out !== 2'b00 || data_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_rst_out got=%b%b%b exp=0000",
                            enable_out, data_valid, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NS; k++) begin
            set_in(1, 0, 0, 0);
            cur_word = RR'(k + 1);
            in_data  = {in_data[2*RR-1:RR], cur_word ^ in_data[2*RR-1:RR]};
            #1;
            total++;
            if (enable_out !== 2'b11 || fetch_out !== 1'b1 || in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_word%0d got=%b%b%b exp=1111",
                                k, enable_out, fetch_out, in_ready);
            end
            tick();
        end
        set_in(1, 0, 0, 0);
        #1;
        total++;
        if (data_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_full got=%b%b%b exp=100", data_valid, in_ready, busy);
        end
        total++;
        if (enable_out !== 2'b00) begin
            bad++; $display("FAIL b2b_full_enable got=%b exp=00", enable_out);
        end
        total++;
        if (holder_ok() !== 1'b1) begin
            bad++; $display("FAIL b2b_holder got=0 exp=1");
        end
        tick();
    endtask

    task automatic test_gaps();
        set_in(0, 0, 0, 1);
        tick();
        for (int k = 0; k < NS + 5; k++) begin
            bit gap;
            gap = (k >= 8) && (k < 13);
            set_in(!gap, 0, 0, 0);
            #1;
            total++;
            if (enable_out !== (gap ? 2'b00 : 2'b11)) begin
                bad++; $display("FAIL gap_enable%0d got=%b exp=%b",
                                k, enable_out, gap ? 2'b00 : 2'b11);
            end
            total++;
            if (data_valid !== 1'b0) begin
                bad++; $display("FAIL gap_early_valid%0d got=%b exp=0", k, data_valid);
            end
            tick();
        end
        set_in(0, 0, 0, 0);
        #1;
        total++;
        if (data_valid !== 1'b1 || holder_ok() !== 1'b1) begin
            bad++; $display("FAIL gap_full got=%b%b exp=11", data_valid, holder_ok());
        end
        tick();
    endtask

    task automatic test_refresh();
        int hs;
        bit done;
        hs   = 0;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            bit refreshing;
            set_in(0, k % 2 == 1, k == 0, 0);
            #1;
            refreshing = rot_left > 0;
            total++;
            if (enable_out !== ((refreshing && rnd_valid) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL ref_enable%0d got=%b", k, enable_out);
            end
            if (enable_out == 2'b11) begin
                hs++;
                total++;
                if (fetch_out !== 1'b0) begin
                    bad++; $display("FAIL ref_fetch%0d got=%b exp=0", k, fetch_out);
                end
            end
            tick();
            done = (k > 0) && (words.size() == NS) && (rot_left == 0);
        end
        set_in(0, 0, 0, 0);
        #1;
        total++;
        if (hs != NS) begin
            bad++; $display("FAIL ref_handshakes got=%0d exp=%0d", hs, NS);
        end
        total++;
        if (data_valid !== 1'b1 || holder_ok() !== 1'b1) begin
            bad++; $display("FAIL ref_full got=%b%b exp=11", data_valid, holder_ok());
        end
        tick();
    endtask

    task automatic test_flush();
        set_in(0, 0, 0, 1);
        tick();
        for (int k = 0; k < 7; k++) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        set_in(1, 0, 0, 1);
        #1;
        total++;
        if (in_ready !== 1'b0 || enable_out !== 2'b00) begin
            bad++; $display("FAIL flush_block got=%b%b exp=000", in_ready, enable_out);
        end
        tick();
        set_in(1, 0, 0, 0);
        #1;
        total++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_empty got=%b%b%b exp=001", data_valid, busy, in_ready);
        end
        for (int k = 0; k < NS; k++) begin
            set_in(1, 0, 0, 0);
            #1;
            total++;
            if (data_valid !== 1'b0) begin
                bad++; $display("FAIL flush_reload_early%0d got=%b exp=0", k, data_valid);
            end
            tick();
        end
        set_in(0, 0, 0, 0);
        #1;
        total++;
        if (data_valid !== 1'b1 || holder_ok() !== 1'b1) begin
            bad++; $display("FAIL flush_reload got=%b%b exp=11", data_valid, holder_ok());
        end
        tick();
    endtask

    task automatic test_reset_refresh();
        set_in(0, 0, 1, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            set_in(0, 1, 0, 0);
            tick();
        end
        set_in(0, 1, 1, 0);
        #1;
        total++;
        if (busy !== 1'b1 || rnd_ready !== 1'b1) begin
            bad++; $display("FAIL rr_mid got=%b%b exp=11", busy, rnd_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 1, 1, 0);
        #1;
        total++;
        if (rnd_ready !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rr_after got=%b%b%b exp=000", rnd_ready, data_valid, busy);
        end
        total++;
        if (in_ready !== 1'b1 || enable_out !== 2'b00) begin
            bad++; $display("FAIL rr_after_io got=%b%b exp=100", in_ready, enable_out);
        end
        tick();
    endtask

    task automatic test_refresh_during_load();
        set_in(0, 0, 0, 1);
        tick();
        for (int k = 0; k < NS; k++) begin
            set_in(1, 1, 1, 0);
            #1;
            total++;
            if (rnd_ready !== 1'b0 || fetch_out !== 1'b1) begin
                bad++; $display("FAIL rdl_load%0d got=%b%b exp=01", k, rnd_ready, fetch_out);
            end
            tick();
        end
        set_in(0, 0, 1, 0);
        #1;
        total++;
        if (data_valid !== 1'b1) begin
            bad++; $display("FAIL rdl_full got=%b exp=1", data_valid);
        end
        tick();
        set_in(0, 1, 0, 0);
        #1;
        total++;
        if (busy !== 1'b1 || rnd_ready !== 1'b1 || data_valid !== 1'b0) begin
            bad++; $display("FAIL rdl_refresh got=%b%b%b exp=110", busy, rnd_ready, data_valid);
        end
        for (int k = 0; k < NS; k++) begin
            set_in(0, 1, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0);
        #1;
        total++;
        if (data_valid !== 1'b1 || holder_ok() !== 1'b1) begin
            bad++; $display("FAIL rdl_done got=%b%b exp=11", data_valid, holder_ok());
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            bit ef, er, el, eir, err;
            logic [1:0] een;
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                   $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4);
            #1;
            ef  = (words.size() == NS) && (rot_left == 0);
            er  = rot_left > 0;
            el  = (words.size() > 0) && (words.size() < NS);
            eir = !rst && !flush && (words.size() < NS);
            err = !rst && !flush && er;
            een = ((in_valid && eir) || (rnd_valid && err)) ? 2'b11 : 2'b00;
            total++;
            if (in_ready !== eir || rnd_ready !== err) begin
                bad++; $display("FAIL rnd_ready%0d got=%b%b exp=%b%b",
                                k, in_ready, rnd_ready, eir, err);
            end
            total++;
            if (enable_out !== een) begin
                bad++; $display("FAIL rnd_enable%0d got=%b exp=%b", k, enable_out, een);
            end
            total++;
            if (data_valid !== ef || busy !== (el || er)) begin
                bad++; $display("FAIL rnd_status%0d got=%b%b exp=%b%b",
                                k, data_valid, busy, ef, el || er);
            end
            total++;
            if (shares_data_out !== in_data || rnd_rfrsh_out !== rnd_in) begin
                bad++; $display("FAIL rnd_passthru%0d got=%h/%h exp=%h/%h",
                                k, shares_data_out, rnd_rfrsh_out, in_data, rnd_in);
            end
            if (een == 2'b11) begin
                total++;
                if (fetch_out !== !er) begin
                    bad++; $display("FAIL rnd_fetch%0d got=%b exp=%b", k, fetch_out, !er);
                end
            end
            tick();
            if ((words.size() == NS) && (rot_left == 0)) begin
                total++;
                if (holder_ok() !== 1'b1) begin
                    bad++; $display("FAIL rnd_holder%0d got=0 exp=1", k);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            h0[i] = '0;
            h1[i] = '0;
        end
        rot_left = 0;
        rst      = 1'b1;
        set_in(0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_refresh();
        test_gaps();
        test_flush();
        test_reset_refresh();
        test_refresh_during_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msk_holder_loader.md
MSK_HOLDER_LOADER -- requirements
Module: MSK_holder_loader

Interface
REQ-001 Parameter d, default 2, number of shares.
REQ-002 Parameter BITS, default 256, bits per share held by the downstream shift-register holder.
REQ-003 Parameter RFRSH_RATE, default 16, word width per share; SHALL divide BITS; NSTAGES = BITS/RFRSH_RATE.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream word available.
REQ-007 in_ready  output  1  loader accepts a word this cycle.
REQ-008 in_data  input  d*RFRSH_RATE  shared word, share i at bits [i*RFRSH_RATE +: RFRSH_RATE].
REQ-009 rnd_valid  input  1  PRNG word available.
REQ-010 rnd_ready  output  1  loader consumes randomness this cycle.
REQ-011 rnd_in  input  (d-1)*RFRSH_RATE  refresh randomness from PRNG.
REQ-012 refresh_req  input  1  level request to refresh the full holder once.
REQ-013 flush  input  1  discard holder contents.
REQ-014 shares_data_out  output  d*RFRSH_RATE  word to holder data input.
REQ-015 rnd_rfrsh_out  output  (d-1)*RFRSH_RATE  randomness to holder refresh input.
REQ-016 fetch_out  output  1  holder mux select (1 = new data, 0 = refreshed rotation).
REQ-017 enable_out  output  d  holder per-share shift enable.
REQ-018 data_valid  output  1  holder contains a complete, consistent value.
REQ-019 busy  output  1  load or refresh in progress.

Function
REQ-020 FSM states: EMPTY, LOAD, FULL, REFRESH; stage counter cnt of width max(1,clog2(NSTAGES)).
REQ-021 shares_data_out SHALL equal in_data and rnd_rfrsh_out SHALL equal rnd_in combinationally.
REQ-022 in_ready = 1 iff state in {EMPTY, LOAD} and flush = 0.
REQ-023 Word accepted when in_valid & in_ready; accepted word drives fetch_out=1 and enable_out=all-ones that same cycle.
REQ-024 EMPTY: accepted word -> LOAD, cnt=1; if NSTAGES=1 -> FULL directly.
REQ-025 LOAD: accepted word increments cnt; word with cnt=NSTAGES-1 -> FULL, cnt=0; no word -> hold, enable_out=0.
REQ-026 FULL: refresh_req=1 and flush=0 -> REFRESH, cnt=0; otherwise hold with enable_out=0.
REQ-027 rnd_ready = 1 iff state=REFRESH and flush=0.
REQ-028 REFRESH: each cycle with rnd_valid=1 drives fetch_out=0, enable_out=all-ones, increments cnt; at cnt=NSTAGES-1 -> FULL, cnt=0; rnd_valid=0 stalls with enable_out=0.
REQ-029 One REFRESH pass = exactly NSTAGES enabled rotations, so word order in holder is unchanged.
REQ-030 refresh_req sampled only in FULL; ignored in EMPTY, LOAD, REFRESH.
REQ-031 flush=1 in any state -> EMPTY, cnt=0 next cycle; flush has priority over in_valid, rnd_valid, refresh_req; no enable that cycle.
REQ-032 data_valid = 1 iff state=FULL; busy = 1 iff state in {LOAD, REFRESH}.
REQ-033 enable_out bits always all equal; fetch_out=1 whenever enable_out=0 is permitted (don't-care), SHALL be 0 during REFRESH.

Reset
REQ-034 rst=1 at a rising edge -> state EMPTY, cnt=0, regardless of state or other inputs, including mid-LOAD and mid-REFRESH.
REQ-035 During and after reset until new stimulus: in_ready=1 (once rst=0), rnd_ready=0, enable_out=0, data_valid=0, busy=0.

Verification (d=2, BITS=256, RFRSH_RATE=16, NSTAGES=16)
REQ-036 Reset, then 16 back-to-back words 0x0001..0x0010 per share -> 16 cycles enable_out=2'b11, fetch_out=1; data_valid=1 cycle after 16th word; in_ready=0.
REQ-037 Load with in_valid gaps (8 words, 5 idle, 8 words) -> enable_out=0 during gaps; data_valid only after 16th accepted word.
REQ-038 FULL, refresh_req=1, rnd_valid toggling 1/0 -> exactly 16 rnd handshakes, enable_out high only on those cycles, fetch_out=0; returns FULL, holder words unchanged after unmasking.
REQ-039 flush during LOAD at cnt=7 with in_valid=1 -> word not accepted, EMPTY next cycle, data_valid=0, next load restarts cnt at 0.
REQ-040 rst during REFRESH at cnt=9 -> EMPTY next cycle, rnd_ready=0, data_valid=0, busy=0.
REQ-041 refresh_req=1 during LOAD -> ignored; after FULL with refresh_req still 1 -> REFRESH next cycle.
